// File: rtl/uart_tx.sv
// UART transmitter: 8N1 framing with optional even/odd parity and a runtime bit-period prescale.
// Define UART_TX_TWO_STOP_EN to append a second stop bit (STOP2 state) to every frame.
module uart_tx (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] P_DATA,
    input  logic       Data_Valid,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    input  logic [5:0] prescale,
    output logic       TX_OUT,
    output logic       busy,
    output logic       done
);

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned PRESC_W = 6;
    localparam int unsigned BIT_W   = 3;
    localparam int unsigned ST_W    = 3;
    localparam int unsigned MIN_P   = 4;

    localparam logic [ST_W-1:0] IDLE   = 3'd0;
    localparam logic [ST_W-1:0] START  = 3'd1;
    localparam logic [ST_W-1:0] DATA   = 3'd2;
    localparam logic [ST_W-1:0] PARITY = 3'd3;
    localparam logic [ST_W-1:0] STOP   = 3'd4;
`ifdef UART_TX_TWO_STOP_EN
    localparam logic [ST_W-1:0] STOP2  = 3'd5;
`endif

    logic [ST_W-1:0]    state;
    logic [ST_W-1:0]    state_nxt;
    logic [PRESC_W-1:0] edge_cnt;
    logic [PRESC_W-1:0] edge_cnt_nxt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [BIT_W-1:0]   bit_cnt_nxt;
    logic               tx_nxt;
    logic               busy_nxt;
    logic               done_nxt;

    logic [DATA_W-1:0]  data_q;
    logic               par_en_q;
    logic               par_typ_q;
    logic [PRESC_W-1:0] presc_q;

    logic [PRESC_W-1:0] last_edge_c;
    logic               bit_end_c;
    logic               parity_c;
    logic               accept_c;

    // Bit-period bookkeeping from the latched configuration; prescales below 4 are clamped to 4.
    always_comb begin
        last_edge_c = (presc_q < PRESC_W'(MIN_P)) ? PRESC_W'(MIN_P - 1) : (presc_q - PRESC_W'(1));
        bit_end_c   = (edge_cnt == last_edge_c);
        parity_c    = (^data_q) ^ par_typ_q;
        accept_c    = (state == IDLE) && Data_Valid;
    end

    // Next-state logic; the registered outputs are decoded from the state being entered.
    always_comb begin
        state_nxt    = state;
        edge_cnt_nxt = bit_end_c ? '0 : (edge_cnt + PRESC_W'(1));
        bit_cnt_nxt  = bit_cnt;
        done_nxt     = 1'b0;
        tx_nxt       = 1'b1;
        busy_nxt     = 1'b0;

        case (state)
            IDLE: begin
                edge_cnt_nxt = '0;
                bit_cnt_nxt  = '0;
                if (Data_Valid) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end_c) begin
                    state_nxt   = DATA;
                    bit_cnt_nxt = '0;
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                        state_nxt   = par_en_q ? PARITY : STOP;
                        bit_cnt_nxt = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end_c) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (bit_end_c) begin
`ifdef UART_TX_TWO_STOP_EN
                    state_nxt = STOP2;
`else
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
`endif
                end
            end
`ifdef UART_TX_TWO_STOP_EN
            STOP2: begin
                if (bit_end_c) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
`endif
            default: begin
                state_nxt    = IDLE;
                edge_cnt_nxt = '0;
                bit_cnt_nxt  = '0;
            end
        endcase

        // Line level and busy for the state being entered.
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = data_q[bit_cnt_nxt];
            PARITY:  tx_nxt = parity_c;
            default: tx_nxt = 1'b1;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    // State, counters, registered outputs and the per-frame configuration snapshot.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            edge_cnt  <= '0;
            bit_cnt   <= '0;
            TX_OUT    <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            presc_q   <= '0;
        end else begin
            state    <= state_nxt;
            edge_cnt <= edge_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            TX_OUT   <= tx_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            if (accept_c) begin
                data_q    <= P_DATA;
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
                presc_q   <= prescale;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed vector table, hand-written corner sequences
// and randomized frames compared against a bit-period level model of the serial line.
module tb_uart_tx;

`ifdef UART_TX_TWO_STOP_EN
    localparam int STOP_BITS = 2;
`else
    localparam int STOP_BITS = 1;
`endif
    localparam int NVEC = 9;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] prescale;
    logic       TX_OUT;
    logic       busy;
    logic       done;

    int checks;
    int errors;

    uart_tx dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .prescale   (prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy),
        .done       (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       pt;
        logic [5:0] ps;
        int         len1;
        int         len2;
        int         probe_k;
        logic       probe_v;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int period(input logic [5:0] ps);
        return (ps < 6'd4) ? 4 : int'(ps);
    endfunction

    // Expected line level k cycles after the start bit begins.
    function automatic logic model_bit(input logic [7:0] d, input logic pe, input logic pt,
                                       input int p, input int k);
        int b;
        b = k / p;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (b == 9 && pe) return (($countones(d) % 2) == 1) ^ pt;
        return 1'b1;
    endfunction

    // Follows one frame from its first low cycle to the done cycle.
    task automatic watch_frame(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps,
                               input int exp_len, input int probe_k, input logic probe_v,
                               input bit scramble, input int inject_at);
        int k;
        int p;
        int mlen;
        k    = 0;
        p    = period(ps);
        mlen = (9 + int'(pe) + STOP_BITS) * p;
        while (done !== 1'b1 && k < 1000) begin
            if (k < mlen) begin
                check("tx_level", 32'(TX_OUT), 32'(model_bit(d, pe, pt, p, k)));
                check("busy_in_frame", 32'(busy), 32'd1);
            end
            if (k == probe_k) check("probe", 32'(TX_OUT), 32'(probe_v));
            if (scramble) begin
                P_DATA     = 8'($urandom);
                PAR_EN     = 1'($urandom);
                PAR_TYP    = 1'($urandom);
                prescale   = 6'($urandom);
                Data_Valid = 1'($urandom);
            end
            if (k == inject_at) begin
                P_DATA     = 8'hFF;
                Data_Valid = 1'b1;
            end
            if (k == inject_at + 1) Data_Valid = 1'b0;
            @(negedge CLK);
            k++;
        end
        if (scramble) Data_Valid = 1'b0;
        check("frame_len", 32'(k), 32'(exp_len));
        check("done_pulse", 32'(done), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        check("tx_at_done", 32'(TX_OUT), 32'd1);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps,
                              input int exp_len, input int probe_k, input logic probe_v,
                              input bit scramble, input int inject_at);
        @(negedge CLK);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        prescale   = ps;
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        watch_frame(d, pe, pt, ps, exp_len, probe_k, probe_v, scramble, inject_at);
    endtask

    task automatic expect_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            check("idle_done", 32'(done), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_tx", 32'(TX_OUT), 32'd1);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        RST        = 1'b1;
        P_DATA     = 8'h00;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        prescale   = 6'd8;

        //            data    pe    pt    ps     len1 len2 probe_k probe_v
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 6'd8,   80,  88,  20, 1'b0};
        vecs[1] = '{8'h03, 1'b1, 1'b0, 6'd8,   88,  96,  76, 1'b0};
        vecs[2] = '{8'h03, 1'b1, 1'b1, 6'd8,   88,  96,  76, 1'b1};
        vecs[3] = '{8'h07, 1'b1, 1'b0, 6'd8,   88,  96,  76, 1'b1};
        vecs[4] = '{8'h3C, 1'b0, 1'b0, 6'd0,   40,  44,  12, 1'b1};
        vecs[5] = '{8'h81, 1'b1, 1'b1, 6'd3,   44,  48,  36, 1'b1};
        vecs[6] = '{8'h00, 1'b0, 1'b0, 6'd16, 160, 176, 159, 1'b1};
        vecs[7] = '{8'hFF, 1'b1, 1'b0, 6'd63, 693, 756, 597, 1'b0};
        vecs[8] = '{8'h01, 1'b0, 1'b0, 6'd4,   40,  44,   4, 1'b1};

        repeat (2) @(negedge CLK);
        check("rst_tx", 32'(TX_OUT), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        RST = 1'b0;
        expect_idle(2);

        for (int i = 0; i < NVEC; i++) begin
            send_frame(vecs[i].d, vecs[i].pe, vecs[i].pt, vecs[i].ps,
                       (STOP_BITS == 2) ? vecs[i].len2 : vecs[i].len1,
                       vecs[i].probe_k, vecs[i].probe_v, 1'b0, -10);
            expect_idle(2);
        end

        // Request during DATA of a 0x00 frame must be dropped.
        send_frame(8'h00, 1'b0, 1'b0, 6'd8, (9 + STOP_BITS) * 8, -1, 1'b0, 1'b0, 30);
        expect_idle(16);

        // Back-to-back with Data_Valid held high.
        @(negedge CLK);
        P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 6'd4; Data_Valid = 1'b1;
        @(negedge CLK);
        P_DATA = 8'h0F;
        watch_frame(8'h55, 1'b0, 1'b0, 6'd4, (9 + STOP_BITS) * 4, -1, 1'b0, 1'b0, -10);
        @(negedge CLK);
        Data_Valid = 1'b0;
        check("b2b_second_start", 32'(TX_OUT), 32'd0);
        check("b2b_done_low", 32'(done), 32'd0);
        watch_frame(8'h0F, 1'b0, 1'b0, 6'd4, (9 + STOP_BITS) * 4, -1, 1'b0, 1'b0, -10);
        expect_idle(4);

        // Reset during DATA bit 3.
        @(negedge CLK);
        P_DATA = 8'h5A; PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 6'd8; Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        for (int k = 0; k < 35; k++) begin
            check("pre_rst_level", 32'(TX_OUT), 32'(model_bit(8'h5A, 1'b0, 1'b0, 8, k)));
            @(negedge CLK);
        end
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("midrst_tx", 32'(TX_OUT), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        expect_idle(100);
        send_frame(8'hC3, 1'b1, 1'b1, 6'd5, (10 + STOP_BITS) * 5, 47, 1'b1, 1'b0, -10);
        expect_idle(2);

        // Randomized frames with inputs churned mid-frame.
        for (int n = 0; n < 25; n++) begin
            logic [7:0] d;
            logic       pe;
            logic       pt;
            logic [5:0] ps;
            d  = 8'($urandom);
            pe = 1'($urandom);
            pt = 1'($urandom);
            ps = 6'($urandom_range(0, 20));
            send_frame(d, pe, pt, ps, (9 + int'(pe) + STOP_BITS) * period(ps), -1, 1'b0, 1'b1, -10);
            expect_idle(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; port names follow the codebase (CLK, RST).
REQ-002 The block SHALL provide these ports:
- CLK  in  1  system clock; all state updates on rising edge
- RST  in  1  synchronous active-high reset
- P_DATA  in  8  parallel byte to transmit
- Data_Valid  in  1  request to send P_DATA
- PAR_EN  in  1  1 = parity bit inserted
- PAR_TYP  in  1  0 = even parity, 1 = odd parity
- prescale  in  6  CLK cycles per bit period
- TX_OUT  out  1  serial line; idles high
- busy  out  1  high while a frame is in progress
- done  out  1  one-cycle pulse at frame end

Function
REQ-003 The state machine SHALL have the states IDLE, START, DATA, PARITY and STOP, plus STOP2 when REQ-017 applies.
REQ-004 In IDLE, a cycle with Data_Valid=1 SHALL latch P_DATA, PAR_EN, PAR_TYP and prescale, and move to START.
- Data_Valid while busy=1 is ignored, with no queuing.
REQ-005 All outputs SHALL be registered.
- TX_OUT drops to 0 and busy rises on the edge after the accepting edge, so latency is 1 cycle.
REQ-006 Bit period SHALL be P cycles, where P is the latched prescale; latched values 0 to 3 are treated as 4.
- A 6-bit edge counter counts 0 to P-1 and wraps to 0 at each bit boundary.
REQ-007 START SHALL drive TX_OUT=0 for one bit period, then go to DATA.
REQ-008 DATA SHALL send the 8 bits LSB first, one bit period each, using a 3-bit bit counter.
- After bit 7, the next state is PARITY if the latched PAR_EN=1, otherwise STOP.
REQ-009 PARITY SHALL drive the XOR of the latched byte when PAR_TYP=0, and its inverse when PAR_TYP=1, for one bit period.
REQ-010 STOP SHALL drive TX_OUT=1 for one bit period.
REQ-011 On the final stop-bit boundary, the block SHALL go to IDLE, pulse done=1 for exactly one cycle, and drop busy in that same cycle.
REQ-012 Frame length SHALL be (10 + PAR_EN) x P cycles from the first TX_OUT low to done, or (11 + PAR_EN) x P with REQ-017.
REQ-013 A new request SHALL be accepted no earlier than the cycle in which done=1 is visible.
- Consecutive frames are therefore separated by at least one idle-high cycle.
REQ-014 Changes to P_DATA, PAR_EN, PAR_TYP or prescale mid-frame SHALL have no effect on the current frame.
REQ-015 An unreachable state encoding SHALL return to IDLE on the next edge with TX_OUT=1.

Reset
REQ-016 When RST=1 at a rising edge, the block SHALL apply the reset values on that edge, including mid-frame, and the frame in progress is abandoned:
- state = IDLE
- TX_OUT = 1
- busy = 0
- done = 0
- edge counter = 0
- bit counter = 0
- latched registers = 0

Configuration
REQ-017 With macro UART_TX_TWO_STOP_EN defined, STOP SHALL be followed by STOP2, which drives TX_OUT=1 for one more bit period before done.
- Without the macro, STOP2 is not compiled in and the frame has one stop bit.

Verification
REQ-018 Basic frame: P_DATA=0xA5, PAR_EN=0, prescale=8, one-cycle Data_Valid -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1, each bit 8 cycles; done pulses once, 80 cycles after TX_OUT falls.
REQ-019 Parity: P_DATA=0x03 with PAR_EN=1 and PAR_TYP=0 -> parity bit 0; PAR_TYP=1 -> parity bit 1; P_DATA=0x07 with PAR_TYP=0 -> parity bit 1; frame is 88 cycles at prescale=8.
REQ-020 Busy rejection: Data_Valid pulsed with 0xFF during the DATA state of a 0x00 frame -> the 0x00 frame completes unchanged and no second frame starts.
REQ-021 Back-to-back: Data_Valid held high with 0x55 then 0x0F -> two frames, with at least one idle-high cycle between the first stop bit and the second start bit, and two done pulses.
REQ-022 Reset mid-frame: RST=1 for one cycle during bit 3 of DATA -> next edge TX_OUT=1, busy=0, no done; a following request transmits correctly.
REQ-023 Boundaries: prescale=0 -> 4-cycle bits; with UART_TX_TWO_STOP_EN, prescale=16 and PAR_EN=0 -> the stop level lasts 32 cycles and the frame is 176 cycles.
